// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped, write-through data cache controller.
// Holds the FSM state encoding, default field widths and the address field-extraction helper.
package dcache_pkg;

  localparam int ADDR_W_D = 10;
  localparam int DATA_W_D = 32;
  localparam int LINES_D  = 32;
  localparam int WORDS_D  = 4;
  localparam int IDX_W_D  = $clog2(LINES_D);
  localparam int OFF_W_D  = $clog2(WORDS_D);
  localparam int TAG_W_D  = ADDR_W_D - IDX_W_D - OFF_W_D;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REFILL = 2'b01,
    WRITE  = 2'b10
  } state_t;

  // Extracts a width-bit field starting at bit lsb of a word address.
  function automatic int unsigned addr_field(input int unsigned addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Per-line valid/tag store: combinational hit lookup, synchronous tag write, async valid clear.
// Lookup is zero-latency; a write becomes visible to lookups on the cycle after the edge.
module dcache_tag_array #(
  parameter int LINES = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic [IDX_W-1:0] i_lkp_idx,
  input  logic [TAG_W-1:0] i_lkp_tag,
  output logic             o_hit,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_hit = r_valid[i_lkp_idx] && (r_tag[i_lkp_idx] == i_lkp_tag);

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache sequencer (direct-mapped, write-through, no-write-allocate); read hits are zero-latency,
// misses and stores stall the core until memory acks. Optional DCACHE_CTRL_STATS_EN adds hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int LINES  = LINES_D,
  parameter int WORDS  = WORDS_D
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_CTRL_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  state_t              r_state;
  logic [OFF_W-1:0]    r_cnt;
  logic                r_wr_done;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_data [LINES*WORDS];

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [OFF_W-1:0]    w_off;
  logic [OFF_W-1:0]    w_cnt_nxt;
  logic                w_hit;
  logic                w_rd_req;
  logic                w_wr_req;
  logic                w_last_beat;
  logic                w_stall;
  logic [DATA_W-1:0]   w_rdata;

  assign w_tag       = TAG_W'(addr_field(32'(cpu_addr), IDX_W + OFF_W, TAG_W));
  assign w_idx       = IDX_W'(addr_field(32'(cpu_addr), OFF_W, IDX_W));
  assign w_off       = OFF_W'(addr_field(32'(cpu_addr), 0, OFF_W));
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_last_beat = (r_state == REFILL) && mem_ack && (r_cnt == OFF_W'(WORDS - 1));

  // The store just retired is still presented by the core for one IDLE cycle; r_wr_done absorbs it.
  assign w_wr_req = cpu_wr && !r_wr_done;
  assign w_rd_req = cpu_rd && !cpu_wr;

  dcache_tag_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk       (clk),
    .RSTn      (RSTn),
    .i_lkp_idx (w_idx),
    .i_lkp_tag (w_tag),
    .o_hit     (w_hit),
    .i_wr_en   (w_last_beat),
    .i_wr_idx  (r_mem_addr[OFF_W +: IDX_W]),
    .i_wr_tag  (r_mem_addr[ADDR_W-1 -: TAG_W])
  );

  always_comb begin
    w_stall = 1'b1;
    w_rdata = '0;
    if (r_state == IDLE) begin
      w_stall = w_wr_req || (w_rd_req && !w_hit);
      if (w_rd_req && w_hit) begin
        w_rdata = r_data[{w_idx, w_off}];
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr_done   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_wr_req) begin
            r_state     <= WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
          end else if (w_rd_req && !w_hit) begin
            r_state    <= REFILL;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_cnt      <= '0;
            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
          end
        end
        REFILL: begin
          if (mem_ack) begin
            r_cnt      <= w_cnt_nxt;
            r_mem_addr <= {r_mem_addr[ADDR_W-1:OFF_W], w_cnt_nxt};
            if (w_last_beat) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_wr_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == REFILL) && mem_ack) begin
      r_data[{r_mem_addr[OFF_W +: IDX_W], r_cnt}] <= mem_rdata;
    end else if ((r_state == IDLE) && w_wr_req && w_hit) begin
      r_data[{w_idx, w_off}] <= cpu_wdata;
    end
  end

`ifdef DCACHE_CTRL_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_rd_req && w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (!w_wr_req && w_rd_req && !w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

  assign cpu_rdata = w_rdata;
  assign stall     = w_stall;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: memory model with programmable ack delay, cache presence model by index/tag,
// directed scenarios followed by randomized loads/stores.
module tb_dcache_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NL = 32;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          RSTn;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
`ifdef DCACHE_CTRL_STATS_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  dcache_ctrl dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_CTRL_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory: ack arrives when the request has been pending for ack_dly cycles (0 = same cycle).
  logic [DW-1:0] mem [1024];
  int            ack_dly   = 2;
  int            beat_cnt  = 0;
  int            req_cycles = 0;
  logic [AW-1:0] rd_log [$];
  logic [AW-1:0] wr_log [$];
  logic [DW-1:0] wd_log [$];

  always @(negedge clk) begin
    mem_ack   = mem_req && (beat_cnt == ack_dly);
    mem_rdata = mem_ack ? mem[mem_addr] : $urandom;
  end

  always @(posedge clk) begin
    if (!RSTn) begin
      beat_cnt = 0;
    end else if (mem_req) begin
      req_cycles++;
      if (mem_ack) begin
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_log.push_back(mem_addr);
          wd_log.push_back(mem_wdata);
        end else begin
          rd_log.push_back(mem_addr);
        end
        beat_cnt = 0;
      end else begin
        beat_cnt++;
      end
    end
  end

  // Cache presence model: which tag (if any) each index currently holds.
  bit       m_valid [NL];
  bit [2:0] m_tag   [NL];
  int       m_hits   = 0;
  int       m_misses = 0;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int       idx;
    bit [2:0] tg;
    bit       hit;
    int       exp_stall;
    int       cyc;
    int       nrd0, nwr0, nreq0;
    logic [AW-1:0] base;
    idx  = int'(addr[6:2]);
    tg   = addr[9:7];
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    base = {addr[AW-1:2], 2'b00};
    if (wr)       exp_stall = ack_dly + 2;
    else if (hit) exp_stall = 0;
    else          exp_stall = 1 + NW * (ack_dly + 1);
    nrd0  = rd_log.size();
    nwr0  = wr_log.size();
    nreq0 = req_cycles;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    #1;
    cyc = 0;
    while (stall && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq(wr ? "wr_stall_cycles" : "rd_stall_cycles", 32'(cyc), 32'(exp_stall));
    if (!wr) check_eq("rdata", cpu_rdata, mem[addr]);
    if (wr) begin
      check_eq("wr_beats", 32'(wr_log.size() - nwr0), 32'd1);
      check_eq("wr_rd_beats", 32'(rd_log.size() - nrd0), 32'd0);
      if (wr_log.size() > nwr0) begin
        check_eq("wr_addr", 32'(wr_log[nwr0]), 32'(addr));
        check_eq("wr_data", wd_log[nwr0], wd);
      end
    end else if (!hit) begin
      check_eq("refill_beats", 32'(rd_log.size() - nrd0), 32'(NW));
      for (int k = 0; k < NW && (nrd0 + k) < rd_log.size(); k++)
        check_eq("refill_addr", 32'(rd_log[nrd0+k]), 32'(base) + 32'(k));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_misses++;
      m_hits++;
    end else begin
      check_eq("hit_no_req", 32'(req_cycles - nreq0), 32'd0);
      m_hits++;
    end
  endtask

  task automatic idle_chk();
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_addr = 10'($urandom); cpu_wdata = $urandom;
    #1;
    check_eq("idle_stall", 32'(stall), 32'd0);
    check_eq("idle_rdata", cpu_rdata, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    RSTn = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
  endtask

  initial begin
    int cyc;
    int n0;
    logic [AW-1:0] a;
    int r;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    RSTn = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
`ifdef DCACHE_CTRL_STATS_EN
    check_eq("rst_hit_cnt", hit_cnt, 32'd0);
    check_eq("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    @(negedge clk);
    RSTn = 1'b1;

    do_op(1'b1, 1'b0, 10'h004, 32'h0);
    do_op(1'b1, 1'b0, 10'h005, 32'h0);
    do_op(1'b0, 1'b1, 10'h006, 32'hDEADBEEF);
    idle_chk();
    do_op(1'b1, 1'b0, 10'h006, 32'h0);
    check_eq("wr_hit_value", cpu_rdata, 32'hDEADBEEF);
    do_op(1'b0, 1'b1, 10'h3F0, 32'h12345678);
    do_op(1'b1, 1'b0, 10'h3F0, 32'h0);
    do_op(1'b1, 1'b0, 10'h084, 32'h0);
    do_op(1'b1, 1'b0, 10'h004, 32'h0);
    do_op(1'b1, 1'b0, 10'h000, 32'h0);
    do_op(1'b1, 1'b0, 10'h07F, 32'h0);
    do_op(1'b1, 1'b1, 10'h07D, 32'hCAFEF00D);
    do_op(1'b1, 1'b0, 10'h07D, 32'h0);
    ack_dly = 0;
    do_op(1'b0, 1'b1, 10'h001, 32'hA5A5A5A5);
    do_op(1'b1, 1'b0, 10'h104, 32'h0);
    ack_dly = 2;

    // Reset during the third refill beat discards the partial line.
    apply_reset();
    n0 = rd_log.size();
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h004;
    cyc = 0;
    while (rd_log.size() < n0 + 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reset_beats_seen", 32'(rd_log.size() - n0), 32'd2);
    #1;
    RSTn = 1'b0;
    #1;
    check_eq("midrefill_mem_req", 32'(mem_req), 32'd0);
    cpu_rd = 1'b0;
    model_reset();
    @(negedge clk);
    RSTn = 1'b1;
    do_op(1'b1, 1'b0, 10'h004, 32'h0);

    for (int i = 0; i < 80; i++) begin
      if ((i % 10) == 0) ack_dly = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      a[9:7] = 3'($urandom_range(0, 1)) + (($urandom_range(0, 4) == 0) ? 3'd6 : 3'd0);
      case ($urandom_range(0, 3))
        0:       a[6:2] = 5'd0;
        1:       a[6:2] = 5'd31;
        2:       a[6:2] = 5'd1;
        default: a[6:2] = 5'($urandom);
      endcase
      a[1:0] = 2'($urandom);
      if (r < 50)      do_op(1'b1, 1'b0, a, 32'h0);
      else if (r < 85) do_op(1'b0, 1'b1, a, $urandom);
      else if (r < 90) do_op(1'b1, 1'b1, a, $urandom);
      else             idle_chk();
    end
    idle_chk();

`ifdef DCACHE_CTRL_STATS_EN
    check_eq("hit_cnt", hit_cnt, 32'(m_hits));
    check_eq("miss_cnt", miss_cnt, 32'(m_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
